// File: rtl/peripheral_axi4_pkg.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_axi4_pkg
// Brief    : Shared constants, FSM state types and address check helper
// Revision : 1.0 - initial release
// ============================================================================
package peripheral_axi4_pkg;

   localparam int          C_DATA_W    = 32;
   localparam int          C_STRB_W    = C_DATA_W / 8;

   localparam logic [1:0]  C_BURST_FIXED = 2'b00;
   localparam logic [1:0]  C_BURST_INCR  = 2'b01;

   localparam logic [1:0]  C_RESP_OKAY   = 2'b00;
   localparam logic [1:0]  C_RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE = 2'd0,
      W_DATA = 2'd1,
      W_RESP = 2'd2
   } wstate_e;

   typedef enum logic [0:0] {
      R_IDLE = 1'b0,
      R_DATA = 1'b1
   } rstate_e;

   // Addresses below the base wrap to a huge offset, so one compare covers both ends.
   function automatic logic addr_err(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] span);
      logic [31:0] off;
      off = addr - base;
      return (addr[1:0] != 2'b00) || (off >= span);
   endfunction

endpackage
`default_nettype wire

// File: rtl/peripheral_axi4_regfile_mem.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_axi4_regfile_mem
// Brief    : Register array, byte-strobed write port, asynchronous read port
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_axi4_regfile_mem
   import peripheral_axi4_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int IDXW  = $clog2(NREGS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_we,
   input  logic [IDXW-1:0]     i_widx,
   input  logic [C_DATA_W-1:0] i_wdata,
   input  logic [C_STRB_W-1:0] i_wstrb,
   input  logic [IDXW-1:0]     i_ridx,
   output logic [C_DATA_W-1:0] o_rdata
);

   logic [NREGS-1:0][C_DATA_W-1:0] r_mem;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mem <= '0;
      end else if (i_we) begin
         for (int b = 0; b < C_STRB_W; b++) begin
            if (i_wstrb[b]) begin
               r_mem[i_widx][8*b +: 8] <= i_wdata[8*b +: 8];
            end
         end
      end
   end

   assign o_rdata = r_mem[i_ridx];

endmodule
`default_nettype wire

// File: rtl/peripheral_axi4_slave_regfile.sv
`default_nettype none
// ============================================================================
// Module   : peripheral_axi4_slave_regfile
// Brief    : AXI4 slave exposing a bank of 32-bit registers, independent R/W
// Revision : 1.0 - initial release
// ============================================================================
module peripheral_axi4_slave_regfile
   import peripheral_axi4_pkg::*;
#(
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int          NREGS     = 16
) (
   input  logic        aclk,
   input  logic        aresetn,
   input  logic [3:0]  awid,
   input  logic [31:0] awadr,
   input  logic [3:0]  awlen,
   input  logic [1:0]  awburst,
   input  logic        awvalid,
   output logic        awready,
   input  logic [31:0] wrdata,
   input  logic [3:0]  wstrb,
   input  logic        wlast,
   input  logic        wvalid,
   output logic        wready,
   output logic [3:0]  bid,
   output logic [1:0]  bresp,
   output logic        bvalid,
   input  logic        bready,
   input  logic [3:0]  arid,
   input  logic [31:0] araddr,
   input  logic [3:0]  arlen,
   input  logic        arvalid,
   output logic        arready,
   output logic [3:0]  rid,
   output logic [31:0] rdata,
   output logic [1:0]  rresp,
   output logic        rlast,
   output logic        rvalid,
   input  logic        rready
);

   localparam int          IDXW   = $clog2(NREGS);
   localparam logic [31:0] C_SPAN = 32'(NREGS) << 2;

   // ---------------------------------------------------------------- write side
   wstate_e     r_wstate, w_wstate_nxt;
   logic        r_awready, r_wready, r_bvalid;
   logic [3:0]  r_bid;
   logic [1:0]  r_bresp;
   logic [31:0] r_wadr;
   logic [3:0]  r_awlen, r_wbeat;
   logic [1:0]  r_awburst;
   logic        r_werr;

   logic        w_aw_take, w_w_set, w_w_commit, w_b_done;
   logic        w_wfinal, w_wbeat_err, w_wlast_err, w_mem_we;

   assign w_wfinal    = (r_wbeat == r_awlen);
   assign w_wbeat_err = ((r_awburst != C_BURST_FIXED) && (r_awburst != C_BURST_INCR)) ||
                        addr_err(r_wadr, ADDR_BASE, C_SPAN);
   assign w_wlast_err = (wlast != w_wfinal);
   assign w_mem_we    = w_w_commit && !w_wbeat_err;

   always_comb begin
      w_wstate_nxt = r_wstate;
      w_aw_take    = 1'b0;
      w_w_set      = 1'b0;
      w_w_commit   = 1'b0;
      w_b_done     = 1'b0;
      case (r_wstate)
         W_IDLE: begin
            if (awvalid) begin
               w_aw_take    = 1'b1;
               w_wstate_nxt = W_DATA;
            end
         end
         W_DATA: begin
            // wready is raised for one cycle, the beat lands on the edge that drops it
            if (r_wready) begin
               if (wvalid) begin
                  w_w_commit = 1'b1;
                  if (w_wfinal) begin
                     w_wstate_nxt = W_RESP;
                  end
               end
            end else if (wvalid) begin
               w_w_set = 1'b1;
            end
         end
         W_RESP: begin
            if (bready) begin
               w_b_done     = 1'b1;
               w_wstate_nxt = W_IDLE;
            end
         end
         default: w_wstate_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_wstate <= W_IDLE;
      end else begin
         r_wstate <= w_wstate_nxt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_awready <= 1'b0;
         r_wready  <= 1'b0;
         r_bvalid  <= 1'b0;
         r_bid     <= '0;
         r_bresp   <= '0;
         r_wadr    <= '0;
         r_awlen   <= '0;
         r_awburst <= '0;
         r_wbeat   <= '0;
         r_werr    <= 1'b0;
      end else begin
         r_awready <= w_aw_take;
         r_wready  <= w_w_set;
         if (w_aw_take) begin
            r_bid     <= awid;
            r_wadr    <= awadr;
            r_awlen   <= awlen;
            r_awburst <= awburst;
            r_wbeat   <= '0;
            r_werr    <= 1'b0;
         end
         if (w_w_commit) begin
            r_wbeat <= r_wbeat + 4'd1;
            if (r_awburst == C_BURST_INCR) begin
               r_wadr <= r_wadr + 32'd4;
            end
            r_werr <= r_werr | w_wbeat_err | w_wlast_err;
            if (w_wfinal) begin
               r_bvalid <= 1'b1;
               r_bresp  <= (r_werr | w_wbeat_err | w_wlast_err) ? C_RESP_SLVERR : C_RESP_OKAY;
            end
         end
         if (w_b_done) begin
            r_bvalid <= 1'b0;
         end
      end
   end

   // ----------------------------------------------------------------- read side
   rstate_e     r_rstate, w_rstate_nxt;
   logic        r_arready, r_rvalid, r_rlast;
   logic [3:0]  r_rid;
   logic [1:0]  r_rresp;
   logic [31:0] r_rdata;
   logic [31:0] r_radr;
   logic [3:0]  r_arlen, r_rbeat;

   logic        w_ar_take, w_r_load, w_r_done, w_rerr;
   logic [31:0] w_mem_rdata;

   assign w_rerr = addr_err(r_radr, ADDR_BASE, C_SPAN);

   always_comb begin
      w_rstate_nxt = r_rstate;
      w_ar_take    = 1'b0;
      w_r_load     = 1'b0;
      w_r_done     = 1'b0;
      case (r_rstate)
         R_IDLE: begin
            if (arvalid) begin
               w_ar_take    = 1'b1;
               w_rstate_nxt = R_DATA;
            end
         end
         R_DATA: begin
            // A cycle with rvalid low separates every beat from the next
            if (r_rvalid) begin
               if (rready) begin
                  w_r_done = 1'b1;
                  if (r_rlast) begin
                     w_rstate_nxt = R_IDLE;
                  end
               end
            end else begin
               w_r_load = 1'b1;
            end
         end
         default: w_rstate_nxt = R_IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_rstate <= R_IDLE;
      end else begin
         r_rstate <= w_rstate_nxt;
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_arready <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rlast   <= 1'b0;
         r_rid     <= '0;
         r_rresp   <= '0;
         r_rdata   <= '0;
         r_radr    <= '0;
         r_arlen   <= '0;
         r_rbeat   <= '0;
      end else begin
         r_arready <= w_ar_take;
         if (w_ar_take) begin
            r_rid   <= arid;
            r_radr  <= araddr;
            r_arlen <= arlen;
            r_rbeat <= '0;
         end
         if (w_r_load) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rerr ? 32'd0 : w_mem_rdata;
            r_rresp  <= w_rerr ? C_RESP_SLVERR : C_RESP_OKAY;
            r_rlast  <= (r_rbeat == r_arlen);
         end
         if (w_r_done) begin
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
            r_rbeat  <= r_rbeat + 4'd1;
            r_radr   <= r_radr + 32'd4;
         end
      end
   end

   // Base is 64-byte aligned, so the low address bits index the bank directly
   peripheral_axi4_regfile_mem #(
      .NREGS (NREGS),
      .IDXW  (IDXW)
   ) u_mem (
      .clk     (aclk),
      .rst_n   (aresetn),
      .i_we    (w_mem_we),
      .i_widx  (r_wadr[IDXW+1:2]),
      .i_wdata (wrdata),
      .i_wstrb (wstrb),
      .i_ridx  (r_radr[IDXW+1:2]),
      .o_rdata (w_mem_rdata)
   );

   assign awready = r_awready;
   assign wready  = r_wready;
   assign bvalid  = r_bvalid;
   assign bid     = r_bid;
   assign bresp   = r_bresp;
   assign arready = r_arready;
   assign rvalid  = r_rvalid;
   assign rlast   = r_rlast;
   assign rid     = r_rid;
   assign rresp   = r_rresp;
   assign rdata   = r_rdata;

endmodule
`default_nettype wire
